// File: rtl/simmem_pkg.sv
// Shared widths and the AXI write-address request type used by the simulated memory.
package simmem_pkg;
    localparam int DelayWidth = 6;
    localparam int IDWidth    = 4;
    localparam int AddrWidth  = 32;

    typedef struct packed {
        logic [IDWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } waddr_req_t;
endpackage

// File: rtl/simmem_wresp_delay_tracker_if.sv
// Write-address intake and release-token handshakes of the write-response delay tracker.
interface simmem_wresp_delay_tracker_if #(
    parameter int NumSlots   = 8,
    parameter int DelayWidth = simmem_pkg::DelayWidth,
    parameter int IDWidth    = simmem_pkg::IDWidth
);
    logic                              waddr_valid;
    logic                              waddr_ready;
    simmem_pkg::waddr_req_t            waddr;
    logic [DelayWidth-1:0]             delay;
    logic                              release_valid;
    logic                              release_ready;
    logic [IDWidth-1:0]                release_id;
    logic [$clog2(NumSlots+1)-1:0]     occupancy;

    modport master (
        output waddr_valid, waddr, delay, release_ready,
        input  waddr_ready, release_valid, release_id, occupancy
    );

    modport slave (
        input  waddr_valid, waddr, delay, release_ready,
        output waddr_ready, release_valid, release_id, occupancy
    );
endinterface

// File: rtl/simmem_wresp_delay_tracker.sv
// Holds each accepted write request for its programmed delay, then releases its ID
// oldest-first among expired entries, keeping same-ID order and AXI valid stability.
module simmem_wresp_delay_tracker #(
    parameter int NumSlots   = 8,
    parameter int DelayWidth = simmem_pkg::DelayWidth,
    parameter int IDWidth    = simmem_pkg::IDWidth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    simmem_wresp_delay_tracker_if.slave bus
);
    localparam int IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int OccWidth = $clog2(NumSlots + 1);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef enum logic {REL_OPEN, REL_LOCKED} rel_state_e;

    logic [NumSlots-1:0]   valid_q;
    logic [IDWidth-1:0]    id_q    [NumSlots];
    logic [DelayWidth-1:0] cnt_q   [NumSlots];
    // older_q[i][j] set means slot i was accepted before slot j; only meaningful for valid slots.
    logic [NumSlots-1:0]   older_q [NumSlots];
    logic [OccWidth-1:0]   occ_q;
    rel_state_e            state_q, state_d;
    idx_t                  lock_idx_q, lock_idx_d;

    logic [NumSlots-1:0]   eligible;
    logic                  any_eligible;
    logic                  beaten;
    idx_t                  oldest_idx;
    logic                  any_free;
    idx_t                  free_idx;
    idx_t                  sel_idx;
    logic                  rel_valid;
    logic                  release_fire;
    logic                  accept;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            eligible[i] = valid_q[i] && (cnt_q[i] == '0);
            for (int j = 0; j < NumSlots; j++) begin
                if (j != i && valid_q[j] && older_q[j][i] && id_q[j] == id_q[i]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        any_eligible = |eligible;
        oldest_idx   = '0;
        beaten       = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            beaten = 1'b0;
            for (int j = 0; j < NumSlots; j++) begin
                if (j != i && eligible[j] && older_q[j][i]) beaten = 1'b1;
            end
            if (eligible[i] && !beaten) oldest_idx = idx_t'(i);
        end
    end

    always_comb begin
        any_free = ~&valid_q;
        free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = idx_t'(i);
        end
    end

    // A token shown while the bank stalls stays pinned to its slot until the handshake.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        sel_idx    = oldest_idx;
        rel_valid  = any_eligible;
        if (state_q == REL_LOCKED) begin
            sel_idx   = lock_idx_q;
            rel_valid = 1'b1;
        end
        if (!rst_n) rel_valid = 1'b0;
        release_fire = rel_valid && bus.release_ready;
        case (state_q)
            REL_OPEN: begin
                if (rel_valid && !bus.release_ready) begin
                    state_d    = REL_LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            REL_LOCKED: begin
                if (bus.release_ready) state_d = REL_OPEN;
            end
            default: state_d = REL_OPEN;
        endcase
    end

    assign bus.waddr_ready   = rst_n && any_free;
    assign accept            = bus.waddr_valid && bus.waddr_ready;
    assign bus.release_valid = rel_valid;
    assign bus.release_id    = rel_valid ? id_q[sel_idx] : '0;
    assign bus.occupancy     = rst_n ? occ_q : '0;

    // NOTE: sequential state uses non-blocking assignments only; the later accept write
    // to cnt_q deliberately overrides the countdown for the slot being filled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= REL_OPEN;
            lock_idx_q <= '0;
            valid_q    <= '0;
            occ_q      <= '0;
            for (int i = 0; i < NumSlots; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < NumSlots; i++) begin
                if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
            end
            if (release_fire) valid_q[sel_idx] <= 1'b0;
            if (accept) begin
                valid_q[free_idx] <= 1'b1;
                cnt_q[free_idx]   <= bus.delay;
            end
            case ({accept, release_fire})
                2'b10:   occ_q <= occ_q + OccWidth'(1);
                2'b01:   occ_q <= occ_q - OccWidth'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // NOTE: id and age storage is not reset; it is only ever read through valid_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_q[free_idx] <= bus.waddr.id;
            for (int j = 0; j < NumSlots; j++) begin
                older_q[free_idx][j] <= 1'b0;
                if (idx_t'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
            end
        end
    end

    logic unused_waddr;
    assign unused_waddr = ^{bus.waddr.addr, bus.waddr.len, bus.waddr.size, bus.waddr.burst};
endmodule

// File: tb/tb_simmem_wresp_delay_tracker.sv
// Directed bench for the write-response delay tracker: vector table plus full/reset sequences.
module tb_simmem_wresp_delay_tracker;
    import simmem_pkg::*;

    localparam int NumSlots = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simmem_wresp_delay_tracker_if #(
        .NumSlots(NumSlots), .DelayWidth(DelayWidth), .IDWidth(IDWidth)
    ) bus ();

    simmem_wresp_delay_tracker #(
        .NumSlots(NumSlots), .DelayWidth(DelayWidth), .IDWidth(IDWidth)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] n;
        logic       rst;
        logic       vld;
        logic [3:0] id;
        logic [5:0] dly;
        logic       rr;
        logic       e_rdy;
        logic       e_rv;
        logic [3:0] e_id;
        logic [3:0] e_occ;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input int n, input logic r, input logic vld, input int id,
                               input int d, input logic rr, input logic e_rdy,
                               input logic e_rv, input int e_id, input int e_occ);
        vec_t x;
        x.n     = 8'(n);
        x.rst   = r;
        x.vld   = vld;
        x.id    = 4'(id);
        x.dly   = 6'(d);
        x.rr    = rr;
        x.e_rdy = e_rdy;
        x.e_rv  = e_rv;
        x.e_id  = 4'(e_id);
        x.e_occ = 4'(e_occ);
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic vld, input int id, input int d,
                         input logic rr);
        @(negedge clk);
        rst_n              = r;
        bus.waddr_valid    = vld;
        bus.waddr          = '0;
        bus.waddr.id       = 4'(id);
        bus.waddr.addr     = 32'h1000 + 32'(id);
        bus.delay          = 6'(d);
        bus.release_ready  = rr;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic r, input logic e_rdy,
                              input logic e_rv, input int e_id, input int e_occ);
        check({tag, ".ready"}, 32'(bus.waddr_ready), 32'(e_rdy));
        check({tag, ".rvalid"}, 32'(bus.release_valid), 32'(e_rv));
        check({tag, ".occ"}, 32'(bus.occupancy), 32'(e_occ));
        if (e_rv || !r) check({tag, ".rid"}, 32'(bus.release_id), 32'(e_id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        logic seen;

        rst_n             = 1'b0;
        bus.waddr_valid   = 1'b0;
        bus.waddr         = '0;
        bus.delay         = '0;
        bus.release_ready = 1'b0;

        // reset, then single entry id=3 d=5 with a same-cycle accept of id=4 d=0 at its release
        vecs.push_back(v(1, 0, 0, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 3, 5, 1,  1, 0, 0, 0));
        vecs.push_back(v(5, 1, 0, 0, 0, 1,  1, 0, 0, 1));
        vecs.push_back(v(1, 1, 1, 4, 0, 1,  1, 1, 3, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 4, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));
        // reorder across ids
        vecs.push_back(v(1, 1, 1, 1, 10, 1, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 2, 2, 1,  1, 0, 0, 1));
        vecs.push_back(v(2, 1, 0, 0, 0, 1,  1, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 2, 2));
        vecs.push_back(v(6, 1, 0, 0, 0, 1,  1, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 1, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));
        // same-id order: the younger short-delay id=5 waits behind the older one
        vecs.push_back(v(1, 1, 1, 5, 10, 1, 1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 5, 1, 1,  1, 0, 0, 1));
        vecs.push_back(v(9, 1, 0, 0, 0, 1,  1, 0, 0, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 5, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 5, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));
        // back-pressure: id=2 stays presented although older id=1 expires at c6
        vecs.push_back(v(1, 1, 1, 1, 5, 0,  1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 2, 0, 0,  1, 0, 0, 1));
        vecs.push_back(v(8, 1, 0, 0, 0, 0,  1, 1, 2, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 2, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 1, 1, 1));
        vecs.push_back(v(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));

        foreach (vecs[k]) begin
            for (int r = 0; r < int'(vecs[k].n); r++) begin
                drive(vecs[k].rst, vecs[k].vld, int'(vecs[k].id), int'(vecs[k].dly), vecs[k].rr);
                expect_out($sformatf("vec%0d_%0d", k, r), vecs[k].rst, vecs[k].e_rdy,
                           vecs[k].e_rv, int'(vecs[k].e_id), int'(vecs[k].e_occ));
            end
        end

        // full: eight long entries, a rejected ninth, then release one with an accept attempt
        drive(0, 0, 0, 0, 0);
        expect_out("full_rst", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < NumSlots; i++) begin
            drive(1, 1, i, 63, 0);
            expect_out($sformatf("full_acc%0d", i), 1'b1, 1'b1, 1'b0, 0, i);
        end
        drive(1, 1, 9, 63, 0);
        expect_out("full_ninth", 1'b1, 1'b0, 1'b0, 0, 8);
        waited = 0;
        seen   = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            drive(1, 0, 0, 0, 0);
            if (bus.release_valid) seen = 1'b1;
            else waited++;
        end
        check("full_first_token_seen", 32'(seen), 32'd1);
        check("full_wait_cycles", 32'(waited), 32'd55);
        check("full_first_token_id", 32'(bus.release_id), 32'd0);
        check("full_occ_before_release", 32'(bus.occupancy), 32'd8);
        drive(1, 1, 9, 63, 1);
        expect_out("full_rel_and_try", 1'b1, 1'b0, 1'b1, 0, 8);
        drive(1, 1, 9, 63, 0);
        expect_out("full_reaccept", 1'b1, 1'b1, 1'b1, 1, 7);
        drive(1, 0, 0, 0, 0);
        expect_out("full_again", 1'b1, 1'b0, 1'b1, 1, 8);

        // reset mid-operation with a locked token pending
        drive(0, 0, 0, 0, 0);
        expect_out("rst2_a", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(1, 1, i, 0, 0);
        drive(1, 0, 0, 0, 0);
        expect_out("rst2_pending", 1'b1, 1'b1, 1'b1, 1, 3);
        drive(0, 0, 0, 0, 1);
        expect_out("rst2_during", 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 1);
            expect_out($sformatf("rst2_quiet%0d", i), 1'b1, 1'b1, 1'b0, 0, 0);
        end
        drive(1, 1, 7, 1, 1);
        expect_out("rst2_new_acc", 1'b1, 1'b1, 1'b0, 0, 0);
        drive(1, 0, 0, 0, 1);
        expect_out("rst2_new_wait", 1'b1, 1'b1, 1'b0, 0, 1);
        drive(1, 0, 0, 0, 1);
        expect_out("rst2_new_rel", 1'b1, 1'b1, 1'b1, 7, 1);
        drive(1, 0, 0, 0, 1);
        expect_out("rst2_new_done", 1'b1, 1'b1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
